// File: rtl/alu_pipe.sv
// alu_pipe: two-stage registered 16-op ALU with valid/ready on both sides.
// Stage 1 captures the request, stage 2 executes and holds the result until taken.
module alu_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       INST,
   input  logic             SEL,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Z,
   output logic [TAG_W-1:0] out_tag,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic [15:0]      op_count
);
   localparam int M = WIDTH - 1;
   typedef enum logic [3:0] {
      OP_ADD, OP_NEGA, OP_AND, OP_OR, OP_XOR, OP_NOTA, OP_SELAB, OP_SELBA,
      OP_SUB, OP_ALTB, OP_ALEB, OP_AGTB, OP_AGEB, OP_AEQB, OP_ANEB, OP_SELXORB
   } op_e;
   logic [WIDTH-1:0] a_q, b_q;
   logic [3:0]       inst_q;
   logic             sel_q;
   logic [TAG_W-1:0] tag1_q;
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] z_q, z_d, res;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             fz_q, fz_d, fc_q, fc_d, fv_q, fv_d;
   logic             out_valid_q, out_valid_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             s1_adv, s2_adv, arith, lt, eq, cin;
   logic [WIDTH-1:0] x, y;
   logic [WIDTH:0]   sum;
   op_e              op;
   assign op       = op_e'(inst_q);
   assign s2_adv   = s1_valid_q && (!out_valid_q || out_ready);
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;
   // ADD, SUB and NEGA share one adder: SUB is A+~B+1, NEGA is ~A+0+1
   assign x     = op == OP_NEGA ? ~a_q : a_q;
   assign y     = op == OP_SUB ? ~b_q : op == OP_NEGA ? '0 : b_q;
   assign cin   = op == OP_SUB || op == OP_NEGA;
   assign sum   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
   assign arith = op inside {OP_ADD, OP_SUB, OP_NEGA};
   assign lt    = $signed(a_q) < $signed(b_q);
   assign eq    = a_q == b_q;
   always_comb begin
      res = '0;
      case (op)
         OP_ADD, OP_SUB, OP_NEGA: res = sum[M:0];
         OP_AND:     res = a_q & b_q;
         OP_OR:      res = a_q | b_q;
         OP_XOR:     res = a_q ^ b_q;
         OP_NOTA:    res = ~a_q;
         OP_SELAB:   res = sel_q ? b_q : a_q;
         OP_SELBA:   res = sel_q ? a_q : b_q;
         OP_ALTB:    res[0] = lt;
         OP_ALEB:    res[0] = lt || eq;
         OP_AGTB:    res[0] = !(lt || eq);
         OP_AGEB:    res[0] = !lt;
         OP_AEQB:    res[0] = eq;
         OP_ANEB:    res[0] = !eq;
         OP_SELXORB: res = b_q ^ {{M{1'b0}}, sel_q};
         default:    res = '0;
      endcase
   end
   always_comb begin
      s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
      out_valid_d = s2_adv || (out_valid_q && !out_ready);
      z_d         = s2_adv ? res : z_q;
      tag_d       = s2_adv ? tag1_q : tag_q;
      fz_d        = s2_adv ? res == '0 : fz_q;
      fc_d        = s2_adv ? arith && sum[WIDTH] : fc_q;
      fv_d        = s2_adv ? arith && x[M] == y[M] && sum[M] != x[M] : fv_q;
      cnt_d       = cnt_q + {15'd0, out_valid_q && out_ready};
   end
   always_ff @(posedge clk) begin
      if (in_valid && s1_adv) begin
         a_q    <= A;
         b_q    <= B;
         inst_q <= INST;
         sel_q  <= SEL;
         tag1_q <= in_tag;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         z_q         <= '0;
         tag_q       <= '0;
         fz_q        <= 1'b0;
         fc_q        <= 1'b0;
         fv_q        <= 1'b0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         z_q         <= z_d;
         tag_q       <= tag_d;
         fz_q        <= fz_d;
         fc_q        <= fc_d;
         fv_q        <= fv_d;
         cnt_q       <= cnt_d;
      end
   end
   assign out_valid = out_valid_q;
   assign Z         = z_q;
   assign out_tag   = tag_q;
   assign flag_z    = fz_q;
   assign flag_c    = fc_q;
   assign flag_v    = fv_q;
   assign op_count  = cnt_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe; a 64-bit reference model predicts
// every result at request transfer and the monitor compares at result transfer.
module tb_alu_pipe;
   typedef struct {
      logic [31:0] z;
      logic [3:0]  tag;
      logic        c;
      logic        v;
   } exp_t;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready, SEL = 1'b0, out_valid, out_ready = 1'b0;
   logic        flag_z, flag_c, flag_v;
   logic [31:0] A = '0, B = '0, Z;
   logic [3:0]  INST = '0, in_tag = '0, out_tag;
   logic [15:0] op_count;
   int          errs = 0, checks = 0, n_out = 0, n_runs = 0;
   logic        prev_ov = 1'b0, last_c, last_v, last_fz;
   logic [31:0] last_z;
   exp_t        sb[$];
   exp_t        e;
   alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .INST(INST), .SEL(SEL), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .Z(Z), .out_tag(out_tag),
      .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .op_count(op_count)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic s, input logic [3:0] t);
      exp_t   m;
      longint xa, xb, r;
      logic [63:0] u;
      xa = longint'($signed(a));
      xb = longint'($signed(b));
      m.tag = t;
      m.c = 1'b0;
      m.v = 1'b0;
      m.z = '0;
      case (op)
         4'd0: begin
            r = xa + xb;
            u = {32'd0, a} + {32'd0, b};
            m.z = a + b;
            m.c = u[32];
            m.v = r > 64'sd2147483647 || r < -64'sd2147483648;
         end
         4'd1: begin
            r = -xa;
            m.z = -a;
            m.c = a == 0;
            m.v = r > 64'sd2147483647;
         end
         4'd2:  m.z = a & b;
         4'd3:  m.z = a | b;
         4'd4:  m.z = a ^ b;
         4'd5:  m.z = ~a;
         4'd6:  m.z = s ? b : a;
         4'd7:  m.z = s ? a : b;
         4'd8: begin
            r = xa - xb;
            m.z = a - b;
            m.c = a >= b;
            m.v = r > 64'sd2147483647 || r < -64'sd2147483648;
         end
         4'd9:  m.z = 32'(xa < xb);
         4'd10: m.z = 32'(xa <= xb);
         4'd11: m.z = 32'(xa > xb);
         4'd12: m.z = 32'(xa >= xb);
         4'd13: m.z = 32'(xa == xb);
         4'd14: m.z = 32'(xa != xb);
         default: m.z = b ^ {31'd0, s};
      endcase
      return m;
   endfunction
   always @(negedge clk) begin
      prev_ov <= rst_n && out_valid;
      if (rst_n && out_valid && !prev_ov) n_runs <= n_runs + 1;
      if (rst_n && out_valid && out_ready) begin
         n_out   <= n_out + 1;
         last_z  <= Z;
         last_c  <= flag_c;
         last_v  <= flag_v;
         last_fz <= flag_z;
         check("sb_nonempty", 64'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("z", Z, e.z);
            check("tag", out_tag, e.tag);
            check("flag_c", flag_c, e.c);
            check("flag_v", flag_v, e.v);
            check("flag_z", flag_z, 64'(e.z == 0));
         end
      end
      if (rst_n && in_valid && in_ready) sb.push_back(model(INST, A, B, SEL, in_tag));
   end
   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [3:0] t, output int waits);
      in_valid = 1'b1;
      INST = op;
      A = a;
      B = b;
      SEL = s;
      in_tag = t;
      for (waits = 0; waits < 200; waits++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (waits == 200) check("send_ready", in_ready, 1);
      @(posedge clk);
      #1;
   endtask
   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      #1;
      check("drained", sb.size(), 0);
   endtask
   task automatic one(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [3:0] t);
      int w;
      send(op, a, b, s, t, w);
      in_valid = 1'b0;
      drain();
   endtask
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      int w, acc, base, runs0, stalls;
      logic [31:0] z0;
      logic [3:0] t0;
      bit have, xfer;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_z", Z, 0);
      check("rst_tag", out_tag, 0);
      check("rst_flags", {flag_z, flag_c, flag_v}, 0);
      check("rst_count", op_count, 0);
      rst_n = 1'b1;
      check("rst_in_ready", in_ready, 1);
      // first op: latency and overflow flags
      out_ready = 1'b1;
      send(4'd0, 32'h7FFFFFFF, 32'h1, 1'b0, 4'd3, w);
      in_valid = 1'b0;
      @(negedge clk);
      check("lat_cycle1", out_valid, 0);
      @(negedge clk);
      check("lat_cycle2", out_valid, 1);
      check("add_z", Z, 32'h80000000);
      check("add_v", flag_v, 1);
      check("add_c", flag_c, 0);
      check("add_fz", flag_z, 0);
      check("add_tag", out_tag, 3);
      @(posedge clk);
      #1;
      check("add_count", op_count, 1);
      // back-to-back stream of all 16 ops
      base = n_out;
      runs0 = n_runs;
      stalls = 0;
      for (int i = 0; i < 16; i++) begin
         send(4'(i), $urandom, $urandom, 1'($urandom), 4'(i), w);
         stalls += w;
      end
      in_valid = 1'b0;
      drain();
      check("stream_stalls", stalls, 0);
      check("stream_outs", n_out - base, 16);
      check("stream_runs", n_runs - runs0, 1);
      // directed corner cases
      one(4'd1, 32'h80000000, 32'h0, 1'b0, 4'd1);
      check("nega_z", last_z, 32'h80000000);
      check("nega_v", last_v, 1);
      one(4'd8, 32'd5, 32'd5, 1'b0, 4'd2);
      check("sub_z", last_z, 0);
      check("sub_fz", last_fz, 1);
      check("sub_c", last_c, 1);
      one(4'd9, 32'hFFFFFFFF, 32'h1, 1'b0, 4'd4);
      check("altb", last_z, 1);
      one(4'd11, 32'hFFFFFFFF, 32'h1, 1'b0, 4'd5);
      check("agtb", last_z, 0);
      one(4'd15, 32'h0, 32'h10, 1'b1, 4'd6);
      check("selxorb", last_z, 32'h11);
      one(4'd6, 32'hA5, 32'h5A, 1'b0, 4'd7);
      check("selab", last_z, 32'hA5);
      one(4'd7, 32'hA5, 32'h5A, 1'b0, 4'd8);
      check("selba", last_z, 32'h5A);
      // backpressure: out_ready low for 5 cycles with requests pending
      out_ready = 1'b0;
      base = n_out;
      acc = 0;
      have = 0;
      z0 = '0;
      t0 = '0;
      in_valid = 1'b1;
      INST = 4'd0;
      A = $urandom;
      B = $urandom;
      in_tag = 4'd9;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         xfer = in_valid && in_ready;
         if (xfer) acc++;
         if (out_valid && !have) begin
            z0 = Z;
            t0 = out_tag;
            have = 1;
         end else if (out_valid) begin
            check("bp_z_hold", Z, z0);
            check("bp_tag_hold", out_tag, t0);
         end
         @(posedge clk);
         #1;
         if (xfer) begin
            INST = 4'd8;
            A = $urandom;
            B = $urandom;
            in_tag = 4'(10 + acc);
         end
      end
      check("bp_accepted", acc, 2);
      check("bp_in_ready", in_ready, 0);
      check("bp_no_out", n_out - base, 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      check("bp_drain_outs", n_out - base, 2);
      // asynchronous reset with two ops in flight
      out_ready = 1'b0;
      send(4'd4, $urandom, $urandom, 1'b0, 4'd1, w);
      send(4'd2, $urandom, $urandom, 1'b0, 4'd2, w);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      check("arst_out_valid", out_valid, 0);
      check("arst_z", Z, 0);
      check("arst_count", op_count, 0);
      check("arst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      base = n_out;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_outs", n_out - base, 0);
      check("post_rst_valid", out_valid, 0);
      // op_count wrap
      for (int i = 0; i < 65535; i++) send(4'($urandom), $urandom, $urandom, 1'($urandom), 4'(i), w);
      in_valid = 1'b0;
      drain();
      check("count_ffff", op_count, 16'hFFFF);
      one(4'd3, $urandom, $urandom, 1'b0, 4'd0);
      check("count_wrap", op_count, 16'h0000);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
